vga_sync_receiver: RTL
======================

# vga_sync_receiver

Sink-side counterpart of the 640x480@60 VGA sync generator. It samples an incoming hsync/vsync/12-bit RGB stream on the pixel clock and recovers pixel coordinates from sync edges alone. It checks line and frame timing, runs a lock state machine, and re-emits active pixels with their coordinates. It sits on the capture/loopback path, for example fed by the existing generator's outputs for self-test or by an external source clocked at 25 MHz.

## Interface
- HD, 640, active pixels per line
- HF, 16, horizontal front porch
- HS, 96, hsync pulse width
- HB, 48, horizontal back porch
- HT, 800, total clocks per line
- VD, 480, active lines
- VF, 10, vertical front porch
- VS, 2, vsync width in lines
- VB, 33, vertical back porch
- VT, 525, total lines per frame
- LOCK_FRAMES, 2, consecutive good frames required for lock
- clk  in  1  pixel clock (25 MHz); one sample per cycle
- rst  in  1  reset; asynchronous, active-low
- hsync  in  1  active-low horizontal sync
- vsync  in  1  active-low vertical sync
- rgb_in  in  12  {R,G,B} pixel, 4 bits each
- valid  out  1  rgb_out/h_cnt/v_cnt carry an active pixel
- h_cnt  out  10  column 0..HD-1; 0 when valid=0
- v_cnt  out  10  row 0..VD-1; 0 when valid=0
- rgb_out  out  12  registered pixel; 12'h000 when valid=0
- frame_start  out  1  one-cycle pulse coincident with valid pixel (0,0)
- locked  out  1  timing lock
- err_cnt  out  8  saturating count of timing violations

## Operation
- Edge detect: previous-sample flops for hsync and vsync reset to 1. An H-edge is a cycle where hsync=0 and the previous sample was 1.
- Horizontal position p: 0 on the H-edge cycle, then +1 per cycle. It saturates at 2*HT.
- Line length: p+1 at the cycle before an H-edge, i.e. the cycles between consecutive H-edges. It is checked against HT at every H-edge except the first after reset or timeout.
- F-edge: an H-edge with vsync sampled 0 whose preceding H-edge had vsync sampled 1.
- Line index q: 0 at an F-edge, +1 at every other H-edge. It saturates at 1023.
- Frame length: the number of H-edges from one F-edge up to and including the next. It is checked against VT at each F-edge.
- Active pixel: HS+HB ≤ p < HS+HB+HD and VS+VB ≤ q < VS+VB+VD, giving column p−(HS+HB) and row q−(VS+VB). The generator's 640x480 output maps exactly onto columns 0..639 and rows 0..479.
- Output gating: valid=1 only when the input sample is an active pixel and locked=1.
- Lock FSM:
  - SEARCH: entered at reset and on timeout. The first F-edge moves to TRACK with good=0.
  - TRACK: at each F-edge, a frame is good if every line length in it was HT and the frame length was VT. A good frame increments good; a bad one clears it. When good reaches LOCK_FRAMES, move to LOCKED.
  - LOCKED: a bad line length (at its H-edge) or a bad frame length (at its F-edge) moves to TRACK with good=0.
  - locked=1 only in LOCKED.
- Timeout: p reaching 2*HT with no H-edge forces SEARCH and clears good. The next H-edge does not check line length.
- err_cnt: +1 per bad line length, per bad frame length, and per timeout event. When events coincide in one cycle it increments by 1 only. It saturates at 255.

## Timing
- Reset (rst=0, async) clears valid, h_cnt, v_cnt, rgb_out, frame_start, locked, err_cnt, p, q and good, and puts the FSM in SEARCH. Release is synchronous to the next clk edge.
- Latency: rgb_in sampled at cycle t appears on rgb_out/valid/h_cnt/v_cnt at t+1. frame_start is aligned with the same cycle.
- locked rises the cycle after the F-edge that completes the LOCK_FRAMES-th good frame. It falls the cycle after the offending H-edge or F-edge.
- A violation and an F-edge in the same cycle: the violation wins, so the FSM goes to TRACK and good=0.
- A pixel output in the cycle locked drops is still emitted, because it was registered with the old locked value.
- Asserting rst mid-frame clears valid immediately. Lock must be reacquired from SEARCH.

## Test plan
- Generator-fed clean stream, LOCK_FRAMES=2 → locked=1 one cycle after the 3rd F-edge. Frame 4 emits exactly 307200 valid pixels, with frame_start once, h_cnt 0..639 and v_cnt 0..479. err_cnt=0.
- Colour ramp rgb_in={h[3:0],v[3:0],4'h5} while locked → rgb_out at (639,479) = 12'hFF5, appearing one cycle after its input sample.
- Single line stretched to 801 clocks while locked → locked=0 the cycle after that H-edge. err_cnt=1 (the next F-edge also reports a bad frame, so err_cnt=2 after it). Relock after 2 further good frames.
- hsync held high for 1600 cycles → timeout, FSM in SEARCH, err_cnt +1, valid=0 until relock (3 F-edges after the stream resumes).
- Reset asserted mid-line while locked → all outputs 0 asynchronously. After release, no H-edge is generated if hsync is already low.
- 300 injected bad lines → err_cnt saturates at 255.

Source files
------------

// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - VGA sync receiver: timing recovery, lock FSM and active pixel re-emission
module vga_sync_receiver #(
    parameter int HD          = 640,
    parameter int HF          = 16,
    parameter int HS          = 96,
    parameter int HB          = 48,
    parameter int HT          = HD + HF + HS + HB,
    parameter int VD          = 480,
    parameter int VF          = 10,
    parameter int VS          = 2,
    parameter int VB          = 33,
    parameter int VT          = VD + VF + VS + VB,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb_in,
    output logic        valid,
    output logic [9:0]  h_cnt,
    output logic [9:0]  v_cnt,
    output logic [11:0] rgb_out,
    output logic        frame_start,
    output logic        locked,
    output logic [7:0]  err_cnt
);

    localparam int PW = $clog2(2 * HT + 1);
    localparam int GW = $clog2(LOCK_FRAMES + 1);

    localparam logic [PW-1:0] P_MAX    = PW'(2 * HT);
    localparam logic [PW-1:0] P_PRE    = PW'(2 * HT - 1);
    localparam logic [PW-1:0] P_LAST   = PW'(HT - 1);
    localparam logic [PW-1:0] H_FIRST  = PW'(HS + HB);
    localparam logic [PW-1:0] H_END    = PW'(HS + HB + HD);
    localparam logic [9:0]    V_FIRST  = 10'(VS + VB);
    localparam logic [9:0]    V_END    = 10'(VS + VB + VD);
    localparam logic [9:0]    Q_LAST   = 10'(VT - 1);
    localparam logic [GW-1:0] G_PRE    = GW'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {
        SEARCH,
        TRACK,
        LOCKED
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   good_q, good_d;
    logic            started;        // blocks a false H-edge on the first sample after reset
    logic            hs_prev;
    logic            vs_last_h;      // vsync as sampled at the previous H-edge
    logic [PW-1:0]   pos_q, cur_p;   // pos_q: position of the previous sample
    logic [9:0]      row_q, cur_q;
    logic            line_chk_en;
    logic            frame_chk_en;
    logic            line_err_seen;
    logic            h_edge, f_edge, timeout, bad_line, bad_frame, active, pix_ok;

    assign locked = (state_q == LOCKED);

    // Edge detection, position/row tracking and timing-violation detection for the current sample
    always_comb begin
        h_edge    = started && hs_prev && !hsync;
        f_edge    = h_edge && !vsync && vs_last_h;
        cur_p     = h_edge ? '0 : ((pos_q == P_MAX) ? pos_q : pos_q + 1'b1);
        timeout   = !h_edge && (pos_q == P_PRE);
        bad_line  = h_edge && line_chk_en && (pos_q != P_LAST);
        bad_frame = f_edge && frame_chk_en &&
                    ((row_q != Q_LAST) || line_err_seen || bad_line);
        if (f_edge) begin
            cur_q = '0;
        end else if (h_edge && (row_q != 10'd1023)) begin
            cur_q = row_q + 1'b1;
        end else begin
            cur_q = row_q;
        end
        active = (cur_p >= H_FIRST) && (cur_p < H_END) &&
                 (cur_q >= V_FIRST) && (cur_q < V_END);
        pix_ok = active && (state_q == LOCKED);
    end

    // Lock FSM next state; a timeout or violation overrides any F-edge progress
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        if (timeout) begin
            state_d = SEARCH;
            good_d  = '0;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (f_edge) begin
                        state_d = TRACK;
                        good_d  = '0;
                    end
                end
                TRACK: begin
                    if (f_edge) begin
                        if (bad_frame) begin
                            good_d = '0;
                        end else begin
                            good_d = good_q + 1'b1;
                            if (good_q == G_PRE) begin
                                state_d = LOCKED;
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (bad_line || bad_frame) begin
                        state_d = TRACK;
                        good_d  = '0;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    good_d  = '0;
                end
            endcase
        end
    end

    // Timing state, FSM register, error counter and registered pixel outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= SEARCH;
            good_q        <= '0;
            started       <= 1'b0;
            hs_prev       <= 1'b1;
            vs_last_h     <= 1'b1;
            pos_q         <= '0;
            row_q         <= '0;
            line_chk_en   <= 1'b0;
            frame_chk_en  <= 1'b0;
            line_err_seen <= 1'b0;
            err_cnt       <= '0;
            valid         <= 1'b0;
            h_cnt         <= '0;
            v_cnt         <= '0;
            rgb_out       <= '0;
            frame_start   <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            started <= 1'b1;
            hs_prev <= hsync;
            if (h_edge) begin
                vs_last_h <= vsync;
            end
            pos_q <= cur_p;
            row_q <= cur_q;
            if (timeout) begin
                line_chk_en <= 1'b0;
            end else if (h_edge) begin
                line_chk_en <= 1'b1;
            end
            if (timeout) begin
                frame_chk_en <= 1'b0;
            end else if (f_edge) begin
                frame_chk_en <= 1'b1;
            end
            if (timeout || f_edge) begin
                line_err_seen <= 1'b0;
            end else if (bad_line) begin
                line_err_seen <= 1'b1;
            end
            if ((bad_line || bad_frame || timeout) && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 1'b1;
            end
            valid       <= pix_ok;
            h_cnt       <= pix_ok ? 10'(cur_p - H_FIRST) : '0;
            v_cnt       <= pix_ok ? (cur_q - V_FIRST) : '0;
            rgb_out     <= pix_ok ? rgb_in : '0;
            frame_start <= pix_ok && (cur_p == H_FIRST) && (cur_q == V_FIRST);
        end
    end

endmodule
